// File: rtl/mem_arbiter.sv
// Two-port sequencer for a single-port memory: one transaction at a time, write ack at T+2, read ack at T+3.
// ARB_ROUND_ROBIN_EN selects the round-robin tie-break; undefined gives fixed port-0 priority.
module mem_arbiter #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  inout  wire  [DW-1:0] mem_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t        state, next_state;
  logic          grant_q;  // 0 = port 0, 1 = port 1
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          any_req;
  logic          pick;

  assign any_req = m0_req | m1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port not granted last wins; a lone requester always wins.
  assign pick = (m0_req && m1_req) ? ~last_grant : ~m0_req;

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (state == IDLE && any_req)
      last_grant <= pick;
  end
`else
  assign pick = ~m0_req;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = we_q ? RESP : CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we = (state == ACCESS) && we_q;
    m0_ack = (state == RESP) && !grant_q;
    m1_ack = (state == RESP) && grant_q;
    busy   = (state != IDLE);
  end

  // Request fields are captured once in IDLE so requester changes mid-transaction are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && any_req) begin
      grant_q <= pick;
      we_q    <= pick ? m1_we    : m0_we;
      addr_q  <= pick ? m1_addr  : m0_addr;
      wdata_q <= pick ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == CAPTURE) begin
      if (grant_q)
        m1_rdata <= mem_data;
      else
        m0_rdata <= mem_data;
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = mem_we ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 32x8 memory on the shared bus plus a scoreboard of expected acks.
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 5;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_init = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  wire  [DW-1:0] mem_data;
  logic          busy;

  logic [DW-1:0] mem [32];
  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   model_last = 1'b1;
  bit   prev0 = 1'b0, prev1 = 1'b0;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 8'hA5 : (8'(i * 29) ^ 8'h5A);
  endfunction

  // Memory drives the bus whenever it is not being written.
  assign mem_data = mem_we ? {DW{1'bz}} : mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init)
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    else if (mem_we)
      mem[mem_addr] <= mem_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !mem_init) begin
      if (m0_ack) check("m0_ack_width", 32'(prev0), 32'd0);
      if (m1_ack) check("m1_ack_width", 32'(prev1), 32'd0);
      if (mem_we) begin
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("wr_bus", 32'(mem_data), 32'(sb[0].data));
          check("wr_addr", 32'(mem_addr), 32'(sb[0].addr));
        end
      end
      if (m0_ack || m1_ack) begin
        check("addr_known", 32'($isunknown(mem_addr)), 32'd0);
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_port", 32'(m1_ack), 32'(e.port));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.we) check("rdata", 32'(e.port ? m1_rdata : m0_rdata), 32'(e.data));
        end
      end
    end
    prev0 = m0_ack;
    prev1 = m1_ack;
  end

  task automatic issue(input bit p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_d);
    exp_t n;
    @(negedge clk);
    check("idle_before_issue", 32'(busy), 32'd0);
    check("idle_bus", 32'(mem_data), 32'(mem[mem_addr]));
    n.port = p; n.we = we; n.addr = a; n.data = we ? wd : exp_d;
    n.cyc = cyc + (we ? 2 : 3);
    sb.push_back(n);
    model_last = p;
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd; end
  endtask

  task automatic wait_ack(input bit p);
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (p ? m1_ack : m0_ack) begin
        got = 1'b1;
        if (p) m1_req = 1'b0; else m0_req = 1'b0;
      end
    end
    check(p ? "m1_ack_seen" : "m0_ack_seen", 32'(got), 32'd1);
  endtask

  // Both ports hold reads; port p's k-th read targets base+k. Expected grant order from a small arbitration model.
  task automatic run_pair(input int n0, input int n1, input logic [AW-1:0] b0, input logic [AW-1:0] b1);
    int   r0 = n0, r1 = n1, c0 = n0, c1 = n1, t;
    bit   p;
    exp_t n;
    @(negedge clk);
    check("idle_before_pair", 32'(busy), 32'd0);
    t = cyc;
    for (int k = 0; k < n0 + n1; k++) begin
      if (c0 > 0 && c1 > 0) p = RR ? ~model_last : 1'b0;
      else                  p = (c0 == 0);
      n.port = p; n.we = 1'b0;
      n.addr = p ? b1 + AW'(n1 - c1) : b0 + AW'(n0 - c0);
      n.data = init_val(int'(n.addr));
      n.cyc  = t + 3 + 4 * k;
      sb.push_back(n);
      if (p) c1--; else c0--;
      model_last = p;
    end
    m0_we = 1'b0; m0_addr = b0; m0_req = (n0 > 0);
    m1_we = 1'b0; m1_addr = b1; m1_req = (n1 > 0);
    for (int c = 0; c < 200 && (r0 > 0 || r1 > 0); c++) begin
      @(negedge clk);
      if (m0_ack && r0 > 0) begin
        r0--;
        if (r0 == 0) m0_req = 1'b0; else m0_addr = b0 + AW'(n0 - r0);
      end
      if (m1_ack && r1 > 0) begin
        r1--;
        if (r1 == 0) m1_req = 1'b0; else m1_addr = b1 + AW'(n1 - r1);
      end
    end
    check("pair_done", 32'(r0 + r1), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mem_init = 1'b0;
    check("rst_m0_ack", 32'(m0_ack), 32'd0);
    check("rst_m1_ack", 32'(m1_ack), 32'd0);
    check("rst_m0_rdata", 32'(m0_rdata), 32'd0);
    check("rst_m1_rdata", 32'(m1_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Single read, then write/readback on port 1.
    issue(1'b0, 1'b0, 5'd5, 8'h00, 8'hA5);
    wait_ack(1'b0);
    issue(1'b1, 1'b1, 5'd31, 8'h3C, 8'h00);
    wait_ack(1'b1);
    issue(1'b1, 1'b0, 5'd31, 8'h00, 8'h3C);
    wait_ack(1'b1);
    check("m0_rdata_held", 32'(m0_rdata), 32'hA5);

    // Contention: single read each, then four reads each held continuously.
    run_pair(1, 1, 5'd1, 5'd2);
    run_pair(4, 4, 5'd8, 5'd16);

    // Reset during CAPTURE of a port 0 read.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
    @(negedge clk);
    @(negedge clk);
    check("capture_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    check("rstmid_m0_ack", 32'(m0_ack), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_mem_we", 32'(mem_we), 32'd0);
    check("rstmid_m0_rdata", 32'(m0_rdata), 32'd0);
    check("rstmid_m1_rdata", 32'(m1_rdata), 32'd0);
    repeat (4) @(negedge clk);

    // Recovery after the mid-operation reset.
    issue(1'b1, 1'b0, 5'd31, 8'h00, 8'h3C);
    wait_ack(1'b1);
    check("m0_rdata_after_m1", 32'(m0_rdata), 32'd0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
